// File: rtl/branch_pred_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_ctrl_pkg
// Description : Shared constants, types and helpers for the branch prediction
//               front end (PC width, default table sizes, BTB tag geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pred_ctrl_pkg;

    localparam int c_PC_W      = 32;
    localparam int c_ENTRY_NUM = 256;
    localparam int c_BTB_NUM   = 16;
    localparam int c_BTB_IDX_W = $clog2(c_BTB_NUM);
    // PCs are word aligned, so bits [1:0] take part in neither index nor tag.
    localparam int c_BTB_TAG_W = c_PC_W - c_BTB_IDX_W - 2;

    typedef logic [c_PC_W-1:0] pc_t;

    // Sequential fall-through address of a word-aligned instruction.
    function automatic pc_t seq_pc(input pc_t pc);
        return pc + pc_t'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_pred_ctrl_btb_dm.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_ctrl_btb_dm
// Description : Direct-mapped branch target buffer. Combinational read port,
//               one synchronous write port, valid bits cleared synchronously
//               by cpu_rst. Tags and targets are not reset; the valid bit
//               alone qualifies a hit.
// Ports       : cpu_clk, cpu_rst       - clock, synchronous active-high reset
//               rd_idx, rd_tag         - lookup index / tag
//               rd_hit, rd_tgt         - lookup result (combinational)
//               wr_en, wr_idx, wr_tag, wr_tgt - install / overwrite an entry
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_ctrl_btb_dm #(
    parameter int BTB_NUM = 16,
    parameter int IDX_W   = $clog2(BTB_NUM),
    parameter int TAG_W   = 26,
    parameter int TGT_W   = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [TGT_W-1:0] rd_tgt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [TGT_W-1:0] wr_tgt
);

    logic [BTB_NUM-1:0] r_vld;
    logic [TAG_W-1:0]   r_tag [BTB_NUM];
    logic [TGT_W-1:0]   r_tgt [BTB_NUM];

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_vld <= '0;
        end else if (wr_en) begin
            r_vld[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            r_tag[wr_idx] <= wr_tag;
            r_tgt[wr_idx] <= wr_tgt;
        end
    end

    // Read sees the contents before any write on the same edge.
    assign rd_hit = r_vld[rd_idx] && (r_tag[rd_idx] == rd_tag);
    assign rd_tgt = r_tgt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_ctrl
// Description : Fetch-side front end and EX-side update controller for the
//               direction predictor. F1 drives the predictor read index and
//               looks up the BTB; F2 combines the registered BTB result with
//               the predictor direction bit into a next-PC prediction. EX
//               resolution drives the predictor write strobe, trains the BTB,
//               detects mispredictions and issues redirects.
// Ports       : cpu_clk / cpu_rst                  - clock, sync active-high reset
//               if_req_vld, if_pc, if_stall         - fetch request / stall
//               predictor_raddr                     - predictor read index
//               rec_10_entry_valid, predictor_rd_data - predictor read data
//               pred_vld, pred_pc, pred_taken, pred_target - F2 prediction
//               ex_br_*, ex_pred_*                  - EX resolution inputs
//               predictor_waddr, predictor_wen, branch_taken_ex - predictor update
//               redirect_vld, redirect_pc           - mispredict restart
//               br_cnt, mispred_cnt                 - statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM  = c_ENTRY_NUM,
    parameter int ADDR_WIDTH = $clog2(ENTRY_NUM),
    parameter int BTB_NUM    = c_BTB_NUM
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    // fetch
    input  logic                  if_req_vld,
    input  logic [31:0]           if_pc,
    input  logic                  if_stall,
    output logic [ADDR_WIDTH-1:0] predictor_raddr,
    input  logic                  rec_10_entry_valid,
    input  logic                  predictor_rd_data,
    output logic                  pred_vld,
    output logic [31:0]           pred_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    // EX resolution
    input  logic                  ex_br_vld,
    input  logic [31:0]           ex_br_pc,
    input  logic                  ex_br_taken,
    input  logic [31:0]           ex_br_target,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    output logic [ADDR_WIDTH-1:0] predictor_waddr,
    output logic                  predictor_wen,
    output logic                  branch_taken_ex,
    output logic                  redirect_vld,
    output logic [31:0]           redirect_pc,
    output logic [31:0]           br_cnt,
    output logic [31:0]           mispred_cnt
);

    localparam int c_BIDX_W = $clog2(BTB_NUM);
    localparam int c_BTAG_W = c_PC_W - c_BIDX_W - 2;

    // F2 stage
    logic  r_f2_vld;
    pc_t   r_f2_pc;
    logic  r_f2_btb_hit;
    pc_t   r_f2_btb_tgt;

    logic  w_btb_hit;
    pc_t   w_btb_tgt;
    logic  w_btb_wen;
    logic  w_redirect;

    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    // ------------------------------------------------------------------
    // F1: predictor index and BTB lookup
    // ------------------------------------------------------------------
    // While stalled the predictor must keep returning the F2 entry, so the
    // read index falls back to the held F2 PC.
    assign predictor_raddr = if_stall ? r_f2_pc[ADDR_WIDTH+1:2]
                                      : if_pc[ADDR_WIDTH+1:2];

    // Reset suppresses training so a mid-stream reset leaves the BTB empty.
    assign w_btb_wen = ex_br_vld & ex_br_taken & ~cpu_rst;

    branch_pred_ctrl_btb_dm #(
        .BTB_NUM (BTB_NUM),
        .IDX_W   (c_BIDX_W),
        .TAG_W   (c_BTAG_W),
        .TGT_W   (c_PC_W)
    ) u_btb (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .rd_idx  (if_pc[c_BIDX_W+1:2]),
        .rd_tag  (if_pc[c_PC_W-1:c_BIDX_W+2]),
        .rd_hit  (w_btb_hit),
        .rd_tgt  (w_btb_tgt),
        .wr_en   (w_btb_wen),
        .wr_idx  (ex_br_pc[c_BIDX_W+1:2]),
        .wr_tag  (ex_br_pc[c_PC_W-1:c_BIDX_W+2]),
        .wr_tgt  (ex_br_target)
    );

    // ------------------------------------------------------------------
    // F2 registers
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_f2_vld     <= 1'b0;
            r_f2_pc      <= '0;
            r_f2_btb_hit <= 1'b0;
            r_f2_btb_tgt <= '0;
        end else begin
            if (!if_stall) begin
                r_f2_vld     <= if_req_vld & ~w_redirect;
                r_f2_pc      <= if_pc;
                r_f2_btb_hit <= w_btb_hit;
                r_f2_btb_tgt <= w_btb_tgt;
            end else if (w_redirect) begin
                // A redirect kills the held request even under stall.
                r_f2_vld <= 1'b0;
            end
        end
    end

    assign pred_vld    = r_f2_vld & ~w_redirect;
    assign pred_pc     = r_f2_pc;
    assign pred_taken  = rec_10_entry_valid & predictor_rd_data & r_f2_btb_hit;
    assign pred_target = pred_taken ? r_f2_btb_tgt : seq_pc(r_f2_pc);

    // ------------------------------------------------------------------
    // EX: predictor update and misprediction detection
    // ------------------------------------------------------------------
    assign predictor_wen   = ex_br_vld & ~cpu_rst;
    assign predictor_waddr = ex_br_pc[ADDR_WIDTH+1:2];
    assign branch_taken_ex = ex_br_taken;

    // The carried target only matters when the branch was actually taken.
    assign w_redirect = ex_br_vld & ~cpu_rst &
                        ((ex_br_taken != ex_pred_taken) |
                         (ex_br_taken & (ex_br_target != ex_pred_target)));

    assign redirect_vld = w_redirect;
    assign redirect_pc  = ex_br_taken ? ex_br_target : seq_pc(ex_br_pc);

    // ------------------------------------------------------------------
    // Statistics counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (ex_br_vld) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pred_ctrl
// Description : Directed self-checking bench for branch_pred_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_ctrl;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        if_req_vld;
    logic [31:0] if_pc;
    logic        if_stall;
    logic [7:0]  predictor_raddr;
    logic        rec_10_entry_valid;
    logic        predictor_rd_data;
    logic        pred_vld;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_br_vld;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [7:0]  predictor_waddr;
    logic        predictor_wen;
    logic        branch_taken_ex;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mis = 0;

    branch_pred_ctrl dut (
        .cpu_clk            (cpu_clk),
        .cpu_rst            (cpu_rst),
        .if_req_vld         (if_req_vld),
        .if_pc              (if_pc),
        .if_stall           (if_stall),
        .predictor_raddr    (predictor_raddr),
        .rec_10_entry_valid (rec_10_entry_valid),
        .predictor_rd_data  (predictor_rd_data),
        .pred_vld           (pred_vld),
        .pred_pc            (pred_pc),
        .pred_taken         (pred_taken),
        .pred_target        (pred_target),
        .ex_br_vld          (ex_br_vld),
        .ex_br_pc           (ex_br_pc),
        .ex_br_taken        (ex_br_taken),
        .ex_br_target       (ex_br_target),
        .ex_pred_taken      (ex_pred_taken),
        .ex_pred_target     (ex_pred_target),
        .predictor_waddr    (predictor_waddr),
        .predictor_wen      (predictor_wen),
        .branch_taken_ex    (branch_taken_ex),
        .redirect_vld       (redirect_vld),
        .redirect_pc        (redirect_pc),
        .br_cnt             (br_cnt),
        .mispred_cnt        (mispred_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Advance past the next rising edge; inputs are driven here and outputs
    // sampled #1 later, well away from either clock edge.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic ex_drive(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_br_vld = v; ex_br_pc = pc; ex_br_taken = tk;
        ex_br_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        tick();
        #1;
        checks++; if (pred_vld !== 1'b0) begin errors++; $display("FAIL rst_pred_vld got %0h exp 0", pred_vld); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got %0h exp 0", pred_taken); end
        checks++; if (redirect_vld !== 1'b0) begin errors++; $display("FAIL rst_redirect got %0h exp 0", redirect_vld); end
        checks++; if (predictor_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %0h exp 0", predictor_wen); end
        checks++; if (pred_pc !== 32'h0) begin errors++; $display("FAIL rst_pred_pc got %0h exp 0", pred_pc); end
        checks++; if (pred_target !== 32'h4) begin errors++; $display("FAIL rst_pred_target got %0h exp 4", pred_target); end
        checks++; if (br_cnt !== 32'h0) begin errors++; $display("FAIL rst_br_cnt got %0h exp 0", br_cnt); end
        checks++; if (mispred_cnt !== 32'h0) begin errors++; $display("FAIL rst_mispred_cnt got %0h exp 0", mispred_cnt); end
        cpu_rst = 1'b0;
    endtask

    task automatic test_first_request();
        if_req_vld = 1'b1; if_pc = 32'h100;
        #1;
        checks++; if (predictor_raddr !== 8'h40) begin errors++; $display("FAIL req_raddr got %0h exp 40", predictor_raddr); end
        tick();
        if_req_vld = 1'b0;
        #1;
        checks++; if (pred_vld !== 1'b1) begin errors++; $display("FAIL req_pred_vld got %0h exp 1", pred_vld); end
        checks++; if (pred_pc !== 32'h100) begin errors++; $display("FAIL req_pred_pc got %0h exp 100", pred_pc); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL req_pred_taken got %0h exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL req_pred_target got %0h exp 104", pred_target); end
    endtask

    task automatic test_btb_train();
        for (int i = 0; i < 10; i++) begin
            ex_drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
            #1;
            if (i == 0) begin
                checks++; if (predictor_wen !== 1'b1) begin errors++; $display("FAIL train_wen got %0h exp 1", predictor_wen); end
                checks++; if (predictor_waddr !== 8'h40) begin errors++; $display("FAIL train_waddr got %0h exp 40", predictor_waddr); end
                checks++; if (branch_taken_ex !== 1'b1) begin errors++; $display("FAIL train_taken_ex got %0h exp 1", branch_taken_ex); end
                checks++; if (redirect_vld !== 1'b0) begin errors++; $display("FAIL train_redirect got %0h exp 0", redirect_vld); end
            end
            tick();
            exp_br++;
        end
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_req_vld = 1'b1; if_pc = 32'h100;
        tick();
        if_req_vld = 1'b0;
        rec_10_entry_valid = 1'b1; predictor_rd_data = 1'b1;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL hit_pred_taken got %0h exp 1", pred_taken); end
        checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL hit_pred_target got %0h exp 200", pred_target); end
        predictor_rd_data = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL hit_nt_pred_taken got %0h exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL hit_nt_pred_target got %0h exp 104", pred_target); end
        predictor_rd_data = 1'b1; rec_10_entry_valid = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_pred_taken got %0h exp 0", pred_taken); end
        predictor_rd_data = 1'b0;
        checks++; if (br_cnt !== 32'(exp_br)) begin errors++; $display("FAIL train_br_cnt got %0d exp %0d", br_cnt, exp_br); end
        checks++; if (mispred_cnt !== 32'(exp_mis)) begin errors++; $display("FAIL train_mispred_cnt got %0d exp %0d", mispred_cnt, exp_mis); end
    endtask

    // 0x600 shares BTB set 0 with 0x100 but carries a different tag.
    task automatic test_same_index();
        ex_drive(1'b1, 32'h600, 1'b1, 32'h640, 1'b1, 32'h640);
        if_req_vld = 1'b1; if_pc = 32'h600;
        tick();
        exp_br++;
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        rec_10_entry_valid = 1'b1; predictor_rd_data = 1'b1;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_idx_pre_update got %0h exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h604) begin errors++; $display("FAIL same_idx_target got %0h exp 604", pred_target); end
        tick();
        if_pc = 32'h100;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_idx_post_taken got %0h exp 1", pred_taken); end
        checks++; if (pred_target !== 32'h640) begin errors++; $display("FAIL same_idx_post_target got %0h exp 640", pred_target); end
        tick();
        if_req_vld = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict got %0h exp 0", pred_taken); end
        rec_10_entry_valid = 1'b0; predictor_rd_data = 1'b0;
    endtask

    task automatic test_mispredict();
        if_req_vld = 1'b1; if_pc = 32'h180;
        tick();
        ex_drive(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0);
        if_pc = 32'h184;
        #1;
        checks++; if (redirect_vld !== 1'b1) begin errors++; $display("FAIL dir_redirect got %0h exp 1", redirect_vld); end
        checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL dir_redirect_pc got %0h exp 400", redirect_pc); end
        checks++; if (pred_vld !== 1'b0) begin errors++; $display("FAIL dir_squash got %0h exp 0", pred_vld); end
        tick();
        exp_br++; exp_mis++;
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_req_vld = 1'b0;
        #1;
        checks++; if (pred_vld !== 1'b0) begin errors++; $display("FAIL dir_f1_discard got %0h exp 0", pred_vld); end
        checks++; if (mispred_cnt !== 32'(exp_mis)) begin errors++; $display("FAIL dir_mispred_cnt got %0d exp %0d", mispred_cnt, exp_mis); end
        ex_drive(1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 32'h480);
        #1;
        checks++; if (redirect_vld !== 1'b1) begin errors++; $display("FAIL tgt_redirect got %0h exp 1", redirect_vld); end
        checks++; if (redirect_pc !== 32'h500) begin errors++; $display("FAIL tgt_redirect_pc got %0h exp 500", redirect_pc); end
        tick();
        exp_br++; exp_mis++;
        ex_drive(1'b1, 32'h304, 1'b0, 32'h999, 1'b0, 32'h777);
        #1;
        checks++; if (redirect_vld !== 1'b0) begin errors++; $display("FAIL nt_ok_redirect got %0h exp 0", redirect_vld); end
        checks++; if (redirect_pc !== 32'h308) begin errors++; $display("FAIL nt_ok_redirect_pc got %0h exp 308", redirect_pc); end
        checks++; if (branch_taken_ex !== 1'b0) begin errors++; $display("FAIL nt_ok_taken_ex got %0h exp 0", branch_taken_ex); end
        tick();
        exp_br++;
        ex_drive(1'b1, 32'h308, 1'b0, 32'h0, 1'b1, 32'h500);
        #1;
        checks++; if (redirect_vld !== 1'b1) begin errors++; $display("FAIL nt_bad_redirect got %0h exp 1", redirect_vld); end
        checks++; if (redirect_pc !== 32'h30c) begin errors++; $display("FAIL nt_bad_redirect_pc got %0h exp 30c", redirect_pc); end
        tick();
        exp_br++; exp_mis++;
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (br_cnt !== 32'(exp_br)) begin errors++; $display("FAIL mp_br_cnt got %0d exp %0d", br_cnt, exp_br); end
        checks++; if (mispred_cnt !== 32'(exp_mis)) begin errors++; $display("FAIL mp_mispred_cnt got %0d exp %0d", mispred_cnt, exp_mis); end
    endtask

    task automatic test_stall();
        if_req_vld = 1'b1; if_pc = 32'h140;
        tick();
        if_stall = 1'b1; if_pc = 32'h1fc;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pred_pc !== 32'h140) begin errors++; $display("FAIL stall_pred_pc[%0d] got %0h exp 140", i, pred_pc); end
            checks++; if (predictor_raddr !== 8'h50) begin errors++; $display("FAIL stall_raddr[%0d] got %0h exp 50", i, predictor_raddr); end
            checks++; if (pred_vld !== 1'b1) begin errors++; $display("FAIL stall_pred_vld[%0d] got %0h exp 1", i, pred_vld); end
            tick();
        end
        ex_drive(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0);
        #1;
        checks++; if (redirect_vld !== 1'b1) begin errors++; $display("FAIL stall_redirect got %0h exp 1", redirect_vld); end
        tick();
        exp_br++; exp_mis++;
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (pred_vld !== 1'b0) begin errors++; $display("FAIL stall_redirect_clear got %0h exp 0", pred_vld); end
        checks++; if (pred_pc !== 32'h140) begin errors++; $display("FAIL stall_redirect_hold got %0h exp 140", pred_pc); end
        if_stall = 1'b0;
        #1;
        checks++; if (predictor_raddr !== 8'h7f) begin errors++; $display("FAIL unstall_raddr got %0h exp 7f", predictor_raddr); end
        tick();
        if_req_vld = 1'b0;
        #1;
        checks++; if (pred_pc !== 32'h1fc) begin errors++; $display("FAIL unstall_pred_pc got %0h exp 1fc", pred_pc); end
        checks++; if (pred_vld !== 1'b1) begin errors++; $display("FAIL unstall_pred_vld got %0h exp 1", pred_vld); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            if_req_vld = 1'b1; if_pc = pcs[i];
            tick();
            checks++; if (pred_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d] got %0h exp 1", i, pred_vld); end
            checks++; if (pred_pc !== pcs[i]) begin errors++; $display("FAIL b2b_pc[%0d] got %0h exp %0h", i, pred_pc, pcs[i]); end
        end
        if_req_vld = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [31:0] pcs [4];
        pcs[0] = 32'h600; pcs[1] = 32'h300; pcs[2] = 32'h700; pcs[3] = 32'h100;
        ex_drive(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 32'h0);
        cpu_rst = 1'b1;
        #1;
        checks++; if (predictor_wen !== 1'b0) begin errors++; $display("FAIL mrst_wen got %0h exp 0", predictor_wen); end
        checks++; if (redirect_vld !== 1'b0) begin errors++; $display("FAIL mrst_redirect got %0h exp 0", redirect_vld); end
        tick();
        cpu_rst = 1'b0;
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++; if (br_cnt !== 32'h0) begin errors++; $display("FAIL mrst_br_cnt got %0d exp 0", br_cnt); end
        checks++; if (mispred_cnt !== 32'h0) begin errors++; $display("FAIL mrst_mispred_cnt got %0d exp 0", mispred_cnt); end
        checks++; if (pred_vld !== 1'b0) begin errors++; $display("FAIL mrst_pred_vld got %0h exp 0", pred_vld); end
        for (int i = 0; i < 4; i++) begin
            if_req_vld = 1'b1; if_pc = pcs[i];
            tick();
            if_req_vld = 1'b0;
            rec_10_entry_valid = 1'b1; predictor_rd_data = 1'b1;
            #1;
            checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mrst_btb_miss[%0h] got %0h exp 0", pcs[i], pred_taken); end
            checks++; if (pred_target !== pcs[i] + 32'd4) begin errors++; $display("FAIL mrst_target[%0h] got %0h exp %0h", pcs[i], pred_target, pcs[i] + 32'd4); end
            rec_10_entry_valid = 1'b0; predictor_rd_data = 1'b0;
        end
    endtask

    initial begin
        cpu_rst = 1'b1;
        if_req_vld = 1'b0; if_pc = 32'h0; if_stall = 1'b0;
        rec_10_entry_valid = 1'b0; predictor_rd_data = 1'b0;
        ex_drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        test_reset();
        test_first_request();
        test_btb_train();
        test_same_index();
        test_mispredict();
        test_stall();
        test_back_to_back();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
